// File: rtl/arith_pkg.sv
// Shared arithmetic-unit constants and types for the sequential divider.
package arith_pkg;

  localparam int unsigned DIV_W     = 16;
  localparam int unsigned DIV_STEPS = 16;
  localparam int unsigned CNT_W     = 4;

  localparam logic [DIV_W-1:0] DBZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/sub_cla_17.sv
// 17-bit subtractor a - b computed as a + ~b + 1 with a Kogge-Stone carry tree.
module sub_cla_17 (
  input  logic [16:0] a_i,
  input  logic [16:0] b_i,
  output logic [16:0] diff_o,
  output logic        cout_o
);

  localparam int unsigned N      = 17;
  localparam int unsigned LEVELS = 5;

  logic [N-1:0] b_inv;
  logic [N-1:0] p_raw;
  logic [N-1:0] g_raw;
  logic [N-1:0] g0;
  logic [N-1:0] g_fin;
  logic [N-1:0] carry;
  logic         unused_p;

  assign b_inv = ~b_i;
  assign p_raw = a_i ^ b_inv;
  assign g_raw = a_i & b_inv;

  // The +1 carry-in is folded into bit 0 as an extra generate term.
  assign g0 = {g_raw[N-1:1], g_raw[0] | p_raw[0]};

  // Prefix levels with spans 1, 2, 4, 8, 16.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned D = 1 << l;
    logic [N-1:0] gi, pi, go, po;

    if (l == 0) begin : g_first
      assign gi = g0;
      assign pi = p_raw;
    end else begin : g_next
      assign gi = g_lvl[l-1].go;
      assign pi = g_lvl[l-1].po;
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i >= D) begin : g_comb
        assign go[i] = gi[i] | (pi[i] & gi[i-D]);
        assign po[i] = pi[i] & pi[i-D];
      end else begin : g_keep
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  assign g_fin    = g_lvl[LEVELS-1].go;
  assign unused_p = ^g_lvl[LEVELS-1].po;

  // Carry into bit i is the group generate of bits [i-1:0] plus carry-in.
  assign carry  = {g_fin[N-2:0], 1'b1};
  assign diff_o = p_raw ^ carry;
  assign cout_o = g_fin[N-1];

endmodule

// File: rtl/div_16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module div_16_seq
  import arith_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     q_q, q_d;
  logic [W:0]       r_q, r_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             no_borrow;
  logic             unused_r_msb;

  assign shifted = {r_q[W-1:0], q_q[W-1]};

  // Trial subtraction of the latched divisor from the shifted partial remainder.
  sub_cla_17 u_sub (
    .a_i    (shifted),
    .b_i    ({1'b0, dvs_q}),
    .diff_o (diff),
    .cout_o (no_borrow)
  );

  // The partial remainder stays below the divisor, so its top bit is always zero.
  assign unused_r_msb = r_q[W];

  // Next-state, datapath update and registered handshake decodes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor != '0) begin
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CNT_W'(DIV_STEPS - 1);
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = W'(DBZ_QUOT);
            r_d     = {1'b0, dividend};
            cnt_d   = '0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (no_borrow) begin
          r_d = diff;
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dvs_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dvs_q       <= dvs_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = q_q;
  assign remainder   = r_q[W-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16_seq.sv
// Randomized and directed bench for div_16_seq against an arithmetic model.
module tb_div_16_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  div_16_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain division, with the divide-by-zero convention.
  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? 16'hFFFF : a / b;
  endfunction
  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 16'd0) ? a : a % b;
  endfunction

  // Transaction-level model: tracks accept/handshake and cycles until the result.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [15:0] m_q, m_r;
  logic        m_dbz;

  always @(posedge clk) begin
    bit acc, hs;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_left = 0;
    end else begin
      if (m_busy && m_left > 0) m_left--;
      if (acc) begin
        m_busy = 1'b1;
        m_left = (divisor == 16'd0) ? 0 : 16;
        m_q    = ref_q(dividend, divisor);
        m_r    = ref_r(dividend, divisor);
        m_dbz  = (divisor == 16'd0);
      end
      if (hs) m_busy = 1'b0;
    end
    #1;
    chk("mon_in_ready", 32'(in_ready), 32'(!m_busy));
    chk("mon_out_valid", 32'(out_valid), 32'(m_busy && m_left == 0));
    if (m_busy && m_left == 0) begin
      chk("mon_quotient", 32'(quotient), 32'(m_q));
      chk("mon_remainder", 32'(remainder), 32'(m_r));
      chk("mon_dbz", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  task automatic junk();
    in_valid = 1'($urandom_range(0, 1));
    dividend = 16'd7;
    divisor  = 16'd2;
  endtask

  // One division: accept, wait for result, hold for 'hold' cycles, handshake.
  task automatic run_div(input logic [15:0] dd, input logic [15:0] dv, input int hold,
                         input bit pulse, input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input int elat);
    int n;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (pulse) junk();
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
    repeat (hold) begin
      if (pulse) junk();
      @(negedge clk);
      chk("held_valid", 32'(out_valid), 32'd1);
      chk("held_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 16'd0;
    divisor   = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;

    // Hand-computed vectors pinning the model and the boundaries.
    run_div(16'd100,   16'd7,      0, 1'b0, 16'd14,     16'd2,    1'b0, 16);
    run_div(16'hFFFF,  16'd1,      1, 1'b0, 16'hFFFF,   16'd0,    1'b0, 16);
    run_div(16'hFFFF,  16'hFFFF,   0, 1'b0, 16'd1,      16'd0,    1'b0, 16);
    run_div(16'h8000,  16'd3,      2, 1'b0, 16'h2AAA,   16'd2,    1'b0, 16);
    run_div(16'd5,     16'd9,      0, 1'b0, 16'd0,      16'd5,    1'b0, 16);
    run_div(16'd0,     16'h1234,   1, 1'b0, 16'd0,      16'd0,    1'b0, 16);
    run_div(16'd1234,  16'd0,      0, 1'b0, 16'hFFFF,   16'd1234, 1'b1, 0);
    run_div(16'd10,    16'd3,      0, 1'b0, 16'd3,      16'd1,    1'b0, 16);
    run_div(16'd200,   16'd13,     20, 1'b1, 16'd15,    16'd5,    1'b0, 16);

    // Reset in the middle of a division.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 16'd500;
    divisor  = 16'd9;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_div(16'd500, 16'd9, 0, 1'b0, 16'd55, 16'd5, 1'b0, 16);

    // Random operands, backpressure and ignored in_valid pulses.
    for (int k = 0; k < 40; k++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 15));
        3:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: b = 16'($urandom);
      endcase
      run_div(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ref_q(a, b), ref_r(a, b), (b == 16'd0), (b == 16'd0) ? 0 : 16);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
